// File: rtl/hdb3_rx_ctrl.sv
// HDB3 receive controller: line-code rule checking, LOS/HUNT/SYNC link tracking,
// decoder gating and a saturating code-violation counter.
module hdb3_rx_ctrl #(
    parameter int unsigned LOS_ZEROS   = 32,
    parameter int unsigned LOCK_SYMS   = 64,
    parameter int unsigned WIN_SYMS    = 256,
    parameter int unsigned UNLOCK_ERRS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  hdb3_code,
    input  logic        cnt_clr,
    output logic        dec_en,
    output logic        dec_flush,
    output logic [1:0]  link_state,
    output logic        cv_err,
    output logic [15:0] cv_count
);

    typedef enum logic [1:0] {
        StLos  = 2'b00,
        StHunt = 2'b01,
        StSync = 2'b10
    } link_state_e;

    localparam logic [7:0]  ZrunMax  = 8'(LOS_ZEROS);
    localparam logic [7:0]  ZrunLast = 8'(LOS_ZEROS - 1);
    localparam logic [9:0]  LockLast = 10'(LOCK_SYMS - 1);
    localparam logic [11:0] WinLast  = 12'(WIN_SYMS - 1);
    localparam logic [3:0]  ErrLast  = 4'(UNLOCK_ERRS - 1);

    link_state_e state_q, state_d;
    logic [7:0]  zrun_q, zrun_d;
    logic        prev_pol_q, prev_pol_d;
    logic        prev_valid_q, prev_valid_d;
    logic        lastv_pol_q, lastv_pol_d;
    logic        lastv_valid_q, lastv_valid_d;
    logic [9:0]  good_q, good_d;
    logic [11:0] win_q, win_d;
    logic [3:0]  err_q, err_d;
    logic        dec_en_q, dec_flush_q, dec_flush_d;
    logic        cv_err_q;
    logic [15:0] cv_count_q, cv_count_d;

    logic is_space, is_mark, is_illegal, mark_pol;
    logic is_v, v_zrun_ok, cv_raw, cv, los_hit;

    // Symbol classification and rule checks
    always_comb begin
        is_space   = (hdb3_code == 2'b00);
        is_mark    = hdb3_code[0];
        is_illegal = (hdb3_code == 2'b10);
        mark_pol   = hdb3_code[1];
        is_v       = is_mark & prev_valid_q & (mark_pol == prev_pol_q);
        v_zrun_ok  = (zrun_q == 8'd2) | (zrun_q == 8'd3);
        cv_raw     = is_illegal
                   | (is_space & (zrun_q == 8'd3))
                   | (is_v & ~v_zrun_ok)
                   | (is_v & lastv_valid_q & (mark_pol == lastv_pol_q));
        cv         = cv_raw & (state_q != StLos);
        los_hit    = is_space & (zrun_q >= ZrunLast);
    end

    // Line history tracking
    always_comb begin
        zrun_d        = zrun_q;
        prev_pol_d    = prev_pol_q;
        prev_valid_d  = prev_valid_q;
        lastv_pol_d   = lastv_pol_q;
        lastv_valid_d = lastv_valid_q;
        if (is_space) begin
            zrun_d = (zrun_q == ZrunMax) ? zrun_q : zrun_q + 8'd1;
        end else if (is_mark) begin
            if (is_v && v_zrun_ok) begin
                lastv_pol_d   = mark_pol;
                lastv_valid_d = 1'b1;
            end
            prev_pol_d   = mark_pol;
            prev_valid_d = 1'b1;
            zrun_d       = 8'd0;
        end
        if (los_hit) begin
            zrun_d        = 8'd0;
            prev_valid_d  = 1'b0;
            lastv_valid_d = 1'b0;
        end
    end

    // Link state machine
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        win_d       = win_q;
        err_d       = err_q;
        dec_flush_d = 1'b0;
        if (los_hit) begin
            state_d     = StLos;
            good_d      = 10'd0;
            win_d       = 12'd0;
            err_d       = 4'd0;
            dec_flush_d = (state_q == StSync);
        end else begin
            unique case (state_q)
                StLos: begin
                    if (is_mark) begin
                        state_d = StHunt;
                        good_d  = 10'd0;
                    end
                end
                StHunt: begin
                    if (cv) begin
                        good_d = 10'd0;
                    end else if (good_q == LockLast) begin
                        state_d = StSync;
                        win_d   = 12'd0;
                        err_d   = 4'd0;
                    end else begin
                        good_d = good_q + 10'd1;
                    end
                end
                StSync: begin
                    if (cv && (err_q == ErrLast)) begin
                        state_d     = StHunt;
                        good_d      = 10'd0;
                        dec_flush_d = 1'b1;
                    end else if (win_q == WinLast) begin
                        win_d = 12'd0;
                        err_d = 4'd0;
                    end else begin
                        win_d = win_q + 12'd1;
                        err_d = err_q + {3'b000, cv};
                    end
                end
                default: state_d = StLos;
            endcase
        end
    end

    // Clear wins over increment, but a coincident violation is still counted
    always_comb begin
        cv_count_d = cv_count_q;
        if (cnt_clr) begin
            cv_count_d = {15'd0, cv};
        end else if (cv && (cv_count_q != 16'hFFFF)) begin
            cv_count_d = cv_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StLos;
            zrun_q        <= 8'd0;
            prev_pol_q    <= 1'b0;
            prev_valid_q  <= 1'b0;
            lastv_pol_q   <= 1'b0;
            lastv_valid_q <= 1'b0;
            good_q        <= 10'd0;
            win_q         <= 12'd0;
            err_q         <= 4'd0;
            dec_en_q      <= 1'b0;
            dec_flush_q   <= 1'b0;
            cv_err_q      <= 1'b0;
            cv_count_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            zrun_q        <= zrun_d;
            prev_pol_q    <= prev_pol_d;
            prev_valid_q  <= prev_valid_d;
            lastv_pol_q   <= lastv_pol_d;
            lastv_valid_q <= lastv_valid_d;
            good_q        <= good_d;
            win_q         <= win_d;
            err_q         <= err_d;
            dec_en_q      <= (state_d == StSync);
            dec_flush_q   <= dec_flush_d;
            cv_err_q      <= cv;
            cv_count_q    <= cv_count_d;
        end
    end

    assign link_state = state_q;
    assign dec_en     = dec_en_q;
    assign dec_flush  = dec_flush_q;
    assign cv_err     = cv_err_q;
    assign cv_count   = cv_count_q;

endmodule

// File: tb/tb_hdb3_rx_ctrl.sv
// Scoreboard bench for hdb3_rx_ctrl: a reference model predicts every cycle's outputs,
// plus directed checks at the scenario milestones.
module tb_hdb3_rx_ctrl;

    localparam int unsigned LosZeros   = 32;
    localparam int unsigned LockSyms   = 64;
    localparam int unsigned WinSyms    = 256;
    localparam int unsigned UnlockErrs = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  hdb3_code = 2'b00;
    logic        cnt_clr = 1'b0;
    logic        dec_en;
    logic        dec_flush;
    logic [1:0]  link_state;
    logic        cv_err;
    logic [15:0] cv_count;

    hdb3_rx_ctrl #(
        .LOS_ZEROS  (LosZeros),
        .LOCK_SYMS  (LockSyms),
        .WIN_SYMS   (WinSyms),
        .UNLOCK_ERRS(UnlockErrs)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hdb3_code (hdb3_code),
        .cnt_clr   (cnt_clr),
        .dec_en    (dec_en),
        .dec_flush (dec_flush),
        .link_state(link_state),
        .cv_err    (cv_err),
        .cv_count  (cv_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic        fl;
        logic        cv;
        logic [15:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cv_seen = 0;

    // Reference model state (0 = LOS, 1 = HUNT, 2 = SYNC)
    int          m_state, m_zrun, m_good, m_win, m_err;
    bit          m_prev_pol, m_prev_valid, m_lastv_pol, m_lastv_valid;
    int unsigned m_count;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_zrun = 0; m_good = 0; m_win = 0; m_err = 0;
        m_prev_pol = 0; m_prev_valid = 0; m_lastv_pol = 0; m_lastv_valid = 0;
        m_count = 0;
    endtask

    task automatic model_step(input logic [1:0] code, input logic clr);
        bit   sp, mk, il, pol, v, cv, fl;
        obs_t e;
        sp  = (code == 2'b00);
        mk  = code[0];
        il  = (code == 2'b10);
        pol = code[1];
        v   = mk && m_prev_valid && (pol == m_prev_pol);
        cv  = il || (sp && m_zrun == 3) || (v && m_zrun != 2 && m_zrun != 3)
            || (v && m_lastv_valid && pol == m_lastv_pol);
        if (m_state == 0) cv = 0;
        fl = 0;
        if (sp) begin
            if (m_zrun < LosZeros) m_zrun++;
        end else if (mk) begin
            if (v && (m_zrun == 2 || m_zrun == 3)) begin
                m_lastv_pol   = pol;
                m_lastv_valid = 1;
            end
            m_prev_pol   = pol;
            m_prev_valid = 1;
            m_zrun       = 0;
        end
        if (sp && m_zrun == LosZeros) begin
            fl = (m_state == 2);
            m_state = 0; m_zrun = 0; m_prev_valid = 0; m_lastv_valid = 0;
            m_good = 0; m_win = 0; m_err = 0;
        end else if (m_state == 0) begin
            if (mk) begin m_state = 1; m_good = 0; end
        end else if (m_state == 1) begin
            if (cv) m_good = 0;
            else begin
                m_good++;
                if (m_good == LockSyms) begin m_state = 2; m_win = 0; m_err = 0; end
            end
        end else begin
            if (cv) m_err++;
            if (m_err == UnlockErrs) begin
                m_state = 1; m_good = 0; fl = 1;
            end else if (m_win == WinSyms - 1) begin
                m_win = 0; m_err = 0;
            end else begin
                m_win++;
            end
        end
        if (clr) m_count = cv ? 1 : 0;
        else if (cv && m_count != 32'hFFFF) m_count++;
        e.st  = 2'(m_state);
        e.en  = (m_state == 2);
        e.fl  = fl;
        e.cv  = cv;
        e.cnt = 16'(m_count);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [1:0] code, input logic clr);
        obs_t got, exp;
        hdb3_code = code;
        cnt_clr   = clr;
        model_step(code, clr);
        @(posedge clk);
        #1;
        got.st  = link_state;
        got.en  = dec_en;
        got.fl  = dec_flush;
        got.cv  = cv_err;
        got.cnt = cv_count;
        exp = exp_q.pop_front();
        check_eq("outs", 32'(got), 32'(exp));
        if (cv_err) cv_seen++;
    endtask

    function automatic logic [1:0] next_mark();
        return (m_prev_valid && !m_prev_pol) ? 2'b11 : 2'b01;
    endfunction

    task automatic send_marks(input int n);
        for (int i = 0; i < n; i++) step(next_mark(), 1'b0);
    endtask

    initial begin
        logic [1:0] a;
        model_reset();
        #12;
        check_eq("rst_state", 32'(link_state), 32'h0);
        check_eq("rst_en", 32'(dec_en), 32'h0);
        check_eq("rst_flush", 32'(dec_flush), 32'h0);
        check_eq("rst_cv", 32'(cv_err), 32'h0);
        check_eq("rst_count", 32'(cv_count), 32'h0);
        rst_n = 1'b1;

        // Acquisition: first mark leaves LOS, 64 clean symbols later SYNC
        step(2'b01, 1'b0);
        check_eq("hunt_first", 32'(link_state), 32'h1);
        send_marks(63);
        check_eq("hunt_m64", 32'(link_state), 32'h1);
        send_marks(1);
        check_eq("sync_m65", 32'(link_state), 32'h2);
        check_eq("sync_en", 32'(dec_en), 32'h1);
        send_marks(35);
        check_eq("acq_count", 32'(cv_count), 32'h0);

        // Legal 000V and B00V substitutions
        cv_seen = 0;
        step(2'b01, 1'b0); step(2'b00, 1'b0); step(2'b00, 1'b0);
        step(2'b00, 1'b0); step(2'b01, 1'b0);
        step(2'b11, 1'b0); step(2'b00, 1'b0); step(2'b00, 1'b0); step(2'b11, 1'b0);
        check_eq("legal_cv", 32'(cv_seen), 32'h0);
        check_eq("legal_state", 32'(link_state), 32'h2);

        // V after a single zero, four times in one window
        for (int r = 0; r < 4; r++) begin
            a = next_mark();
            step(a, 1'b0); step(2'b00, 1'b0); step(a, 1'b0);
            if (r == 0) check_eq("v1_count", 32'(cv_count), 32'h1);
        end
        check_eq("unlock_state", 32'(link_state), 32'h1);
        check_eq("unlock_flush", 32'(dec_flush), 32'h1);
        check_eq("unlock_en", 32'(dec_en), 32'h0);
        send_marks(1);
        check_eq("flush_1cyc", 32'(dec_flush), 32'h0);
        send_marks(63);
        check_eq("relock", 32'(link_state), 32'h2);

        // 32 zeros in SYNC: one cv at the 4th zero, LOS on the 32nd
        cv_seen = 0;
        for (int i = 0; i < 31; i++) step(2'b00, 1'b0);
        check_eq("los_pre", 32'(link_state), 32'h2);
        step(2'b00, 1'b0);
        check_eq("los_state", 32'(link_state), 32'h0);
        check_eq("los_flush", 32'(dec_flush), 32'h1);
        check_eq("los_cv", 32'(cv_seen), 32'h1);

        // Illegal symbol at good_cnt = 63 restarts the lock count
        step(2'b01, 1'b0);
        send_marks(63);
        step(2'b10, 1'b0);
        check_eq("illegal_cv", 32'(cv_err), 32'h1);
        send_marks(63);
        check_eq("hunt_63", 32'(link_state), 32'h1);
        send_marks(1);
        check_eq("hunt_64", 32'(link_state), 32'h2);

        // Counter clear, saturation, clear with coincident cv
        step(next_mark(), 1'b1);
        check_eq("clr_only", 32'(cv_count), 32'h0);
        for (int i = 0; i < 65535; i++) step(2'b10, 1'b0);
        check_eq("sat_reach", 32'(cv_count), 32'hFFFF);
        step(2'b10, 1'b0);
        check_eq("sat_hold", 32'(cv_count), 32'hFFFF);
        step(2'b10, 1'b1);
        check_eq("clr_cv", 32'(cv_count), 32'h1);

        // Asynchronous reset in the middle of SYNC
        send_marks(64);
        check_eq("pre_rst", 32'(link_state), 32'h2);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", 32'(link_state), 32'h0);
        check_eq("arst_en", 32'(dec_en), 32'h0);
        check_eq("arst_flush", 32'(dec_flush), 32'h0);
        check_eq("arst_cv", 32'(cv_err), 32'h0);
        check_eq("arst_count", 32'(cv_count), 32'h0);
        model_reset();
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        step(2'b11, 1'b0);
        check_eq("post_rst", 32'(link_state), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hdb3_rx_ctrl.md
# hdb3_rx_ctrl

Receive-side controller for the HDB3 decode path. It watches the raw 2-bit HDB3 symbol stream that feeds the B/V-removal stage and checks HDB3 line-code rules. It runs a LOS/HUNT/SYNC link state machine and gates the decoder with `dec_en` and a one-cycle `dec_flush`. It also keeps a saturating code-violation counter for status readout.

## Interface
- `LOS_ZEROS`, 32: a run of this many consecutive zero symbols declares loss of signal (range 5..255).
- `LOCK_SYMS`, 64: consecutive violation-free symbols in HUNT needed to enter SYNC (range 1..1023).
- `WIN_SYMS`, 256: length, in symbols, of the SYNC error-monitoring window (range 2..4095).
- `UNLOCK_ERRS`, 4: violations within one window that force SYNC→HUNT (range 1..15).
- `clk  input  1`: symbol clock; one symbol per rising edge. Reset is asynchronous, active-low.
- `rst_n  input  1`: asynchronous, active-low reset.
- `hdb3_code  input  2`: line symbol. 2'b00 = space, 2'b01 = positive mark, 2'b11 = negative mark, 2'b10 = illegal.
- `cnt_clr  input  1`: synchronous clear of `cv_count`.
- `dec_en  output  1`: high only in SYNC; enables the decoder output.
- `dec_flush  output  1`: one-cycle pulse on every exit from SYNC; zeroes the decoder shift buffer.
- `link_state  output  2`: 2'b00 LOS, 2'b01 HUNT, 2'b10 SYNC.
- `cv_err  output  1`: one-cycle pulse per detected violation.
- `cv_count  output  16`: violations since reset or clear; saturates at 16'hFFFF.

## Operation
- Tracked state:
  - `zrun`: zero-run length since the last mark, saturating at LOS_ZEROS.
  - `prev_pol` / `prev_valid`: polarity of the last mark, and whether one exists.
  - `lastv_pol` / `lastv_valid`: polarity of the last V pulse, and whether one exists.
- On reset and on entry to LOS, `prev_valid`, `lastv_valid` and `zrun` are cleared.
- A symbol is a violation (cv) when any of these holds:
  - it is 2'b10;
  - it is a space that brings `zrun` to 4 (flagged once per run, on the 4th zero only);
  - it is a mark with `prev_valid`=1 and the same polarity as `prev_pol` (a V), but `zrun` is not 2 or 3;
  - it is such a V with `lastv_valid`=1 and the same polarity as `lastv_pol`.
- Mark handling:
  - A V with legal `zrun` (2 or 3) updates `lastv_pol`.
  - Every mark updates `prev_pol`, sets `prev_valid`, and clears `zrun`.
  - An illegal 2'b10 symbol leaves `prev_pol` and `zrun` unchanged.
- LOS state:
  - No cv checking; `cv_err` is never asserted.
  - The first mark moves the FSM to HUNT with `good_cnt`=0. That mark only seeds `prev_pol`.
- HUNT state:
  - Each symbol without cv increments `good_cnt`; a cv resets it to 0.
  - When `good_cnt` reaches LOCK_SYMS, the FSM moves to SYNC with `win_cnt`=0 and `err_cnt`=0.
- SYNC state:
  - `win_cnt` counts symbols; each cv increments `err_cnt`.
  - If `err_cnt` reaches UNLOCK_ERRS, the FSM moves to HUNT.
  - Otherwise, when `win_cnt` reaches WIN_SYMS-1, both counters are cleared.
- From any state, `zrun` reaching LOS_ZEROS moves the FSM to LOS. This has priority over every other transition.
- `dec_flush` pulses on SYNC→HUNT and on SYNC→LOS.
- `cv_count` update:
  - It increments on each `cv_err`, saturating.
  - If `cnt_clr` and a cv occur together, `cv_count` loads 1.
  - `cnt_clr` alone loads 0.

## Timing
- All outputs are registered. A symbol sampled at edge k affects outputs after edge k, visible in cycle k+1.
- `cv_err`, the `link_state` change, `dec_en` and `dec_flush` all update on the same edge that samples the deciding symbol.
- `dec_en` rises on the edge that enters SYNC and falls on the edge that leaves it.
- Reset values: `link_state`=LOS, `dec_en`=0, `dec_flush`=0, `cv_err`=0, `cv_count`=0. All internal counters are 0; `prev_valid`=0 and `lastv_valid`=0.
- Asserting `rst_n` low mid-frame clears everything immediately, with no flush pulse.
- The zero run that causes LOS also flags cv at its 4th zero, provided the FSM is not already in LOS.

## Test plan
- Reset, then 100 alternating marks (01,11,…) -> LOS→HUNT on the first mark; SYNC 64 symbols later; `dec_en`=1; `cv_count`=0.
- In SYNC, send the legal sequence 01,00,00,00,01 (000V) and then 11,00,00,11 (B00V with alternating V) -> no `cv_err`; state stays SYNC.
- In SYNC, send 01,00,01 (V after 1 zero) -> one `cv_err` pulse; `cv_count`=1. Repeat 4 times within 256 symbols -> HUNT, with `dec_flush` high for exactly one cycle and `dec_en`=0 on the same edge.
- In SYNC, send 32 zeros -> `cv_err` once at the 4th zero; LOS entered after the 32nd zero; `dec_flush` pulses; `link_state`=2'b00.
- Inject 2'b10 in HUNT at `good_cnt`=63 -> `cv_err` pulses and `good_cnt` returns to 0; SYNC is reached only after 64 further clean symbols.
- With `cv_count`=16'hFFFF, one more cv -> count holds at 16'hFFFF. `cnt_clr` together with a cv -> `cv_count`=1. Asserting `rst_n` low mid-SYNC -> all outputs return to their reset values asynchronously.
